sd_bus_arbiter: RTL and testbench

SD_BUS_ARBITER -- requirements
Module: sd_bus_arbiter

---
 rtl/sd_pkg.sv | 28 ++
 rtl/flex_counter.sv | 56 +++++
 rtl/sd_bus_arbiter.sv | 223 ++++++++++++++++++++++
 tb/tb_sd_bus_arbiter.sv | 371 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sd_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : sd_pkg
//  Description : Shared types and constants for the SD bus arbiter:
//                arbiter state encoding, command word width and the
//                requester identifiers used for round-robin bookkeeping.
//  Revision    : 1.0 - initial release
// ============================================================================
package sd_pkg;

   localparam int SD_CMD_W = 48;

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      GRANT_I = 3'd1,
      GRANT_W = 3'd2,
      GRANT_R = 3'd3,
      RELEASE = 3'd4
   } arb_state_t;

   typedef enum logic [1:0] {
      INIT  = 2'd0,
      WRITE = 2'd1,
      READ  = 2'd2
   } req_id_t;

endpackage
`default_nettype wire

// File: rtl/flex_counter.sv
`default_nettype none
// ============================================================================
//  Module      : flex_counter
//  Description : Up-counter with synchronous clear and programmable
//                rollover value. After reaching rollover_val the next
//                enabled count wraps to 1. rollover_flag is registered and
//                is high while count_out equals rollover_val.
//  Ports       : clk, n_rst (async, active-low), clear, count_enable,
//                rollover_val[NUM_CNT_BITS], count_out[NUM_CNT_BITS],
//                rollover_flag
//  Revision    : 1.0 - initial release
// ============================================================================
module flex_counter #(
   parameter int NUM_CNT_BITS = 4
) (
   input  logic                    clk,
   input  logic                    n_rst,
   input  logic                    clear,
   input  logic                    count_enable,
   input  logic [NUM_CNT_BITS-1:0] rollover_val,
   output logic [NUM_CNT_BITS-1:0] count_out,
   output logic                    rollover_flag
);

   logic [NUM_CNT_BITS-1:0] r_count;
   logic [NUM_CNT_BITS-1:0] w_next_count;
   logic                    r_flag;

   always_comb begin
      w_next_count = r_count;
      if (clear) begin
         w_next_count = '0;
      end else if (count_enable) begin
         if (r_count == rollover_val) begin
            w_next_count = {{(NUM_CNT_BITS-1){1'b0}}, 1'b1};
         end else begin
            w_next_count = r_count + 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         r_count <= '0;
         r_flag  <= 1'b0;
      end else begin
         r_count <= w_next_count;
         r_flag  <= (w_next_count == rollover_val);
      end
   end

   assign count_out     = r_count;
   assign rollover_flag = r_flag;

endmodule
`default_nettype wire

// File: rtl/sd_bus_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : sd_bus_arbiter
//  Description : Arbitrates the SD card SPI shifter between the init, write
//                and read controllers. Init is the only requester served
//                until the card is initialised; afterwards write and read
//                are served round-robin. Each grant is followed by a single
//                RELEASE cycle with CS deasserted.
//  Config      : define SD_ARB_TIMEOUT_EN to build a watchdog that aborts a
//                grant after TIMEOUT_EDGES sclk rising edges and raises
//                timeout_err. Undefined: no watchdog, timeout_err = 0.
//  Ports       : clk, n_rst (async, active-low), rising_edge_sclk,
//                {init,write,read}_{req,done,command,CS,load_command,
//                shift_command,shift_read,load_data,shift_data} in,
//                {init,write,read}_enable, sd_command, sd_CS, load_command,
//                shift_command, shift_read, load_data, shift_data,
//                card_ready, busy, timeout_err out
//  Revision    : 1.0 - initial release
// ============================================================================
module sd_bus_arbiter
   import sd_pkg::*;
#(
   parameter int TIMEOUT_EDGES = 4096
) (
   input  logic                clk,
   input  logic                n_rst,
   input  logic                rising_edge_sclk,
   input  logic                init_req,
   input  logic                write_req,
   input  logic                read_req,
   input  logic                init_done,
   input  logic                write_done,
   input  logic                read_done,
   input  logic [SD_CMD_W-1:0] init_command,
   input  logic [SD_CMD_W-1:0] write_command,
   input  logic [SD_CMD_W-1:0] read_command,
   input  logic                init_CS,
   input  logic                init_load_command,
   input  logic                init_shift_command,
   input  logic                init_shift_read,
   input  logic                init_load_data,
   input  logic                init_shift_data,
   input  logic                write_CS,
   input  logic                write_load_command,
   input  logic                write_shift_command,
   input  logic                write_shift_read,
   input  logic                write_load_data,
   input  logic                write_shift_data,
   input  logic                read_CS,
   input  logic                read_load_command,
   input  logic                read_shift_command,
   input  logic                read_shift_read,
   input  logic                read_load_data,
   input  logic                read_shift_data,
   output logic                init_enable,
   output logic                write_enable,
   output logic                read_enable,
   output logic [SD_CMD_W-1:0] sd_command,
   output logic                sd_CS,
   output logic                load_command,
   output logic                shift_command,
   output logic                shift_read,
   output logic                load_data,
   output logic                shift_data,
   output logic                card_ready,
   output logic                busy,
   output logic                timeout_err
);

   localparam int c_cnt_w = $clog2(TIMEOUT_EDGES + 1);

   arb_state_t r_state;
   arb_state_t w_next_state;
   req_id_t    r_last;
   logic       r_init_en;
   logic       r_write_en;
   logic       r_read_en;
   logic       r_card_ready;
   logic       w_grant_entry;
   logic       w_timeout;

   // ------------------------------------------------------------------------
   // Next-state logic
   // ------------------------------------------------------------------------
   always_comb begin
      w_next_state = r_state;
      case (r_state)
         IDLE: begin
            if (!r_card_ready) begin
               // Data transfers are meaningless before the card is set up.
               if (init_req) w_next_state = GRANT_I;
            end else if (write_req && read_req) begin
               w_next_state = (r_last == WRITE) ? GRANT_R : GRANT_W;
            end else if (write_req) begin
               w_next_state = GRANT_W;
            end else if (read_req) begin
               w_next_state = GRANT_R;
            end
         end
         GRANT_I: if (init_done  || w_timeout) w_next_state = RELEASE;
         GRANT_W: if (write_done || w_timeout) w_next_state = RELEASE;
         GRANT_R: if (read_done  || w_timeout) w_next_state = RELEASE;
         RELEASE: w_next_state = IDLE;
         default: w_next_state = IDLE;
      endcase
   end

   assign w_grant_entry = (r_state == IDLE) && (w_next_state != IDLE);

   // ------------------------------------------------------------------------
   // State, grant and status registers. Grants are decoded from the next
   // state so they rise on the same edge the grant state is entered.
   // ------------------------------------------------------------------------
   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         r_state      <= IDLE;
         r_last       <= READ;
         r_init_en    <= 1'b0;
         r_write_en   <= 1'b0;
         r_read_en    <= 1'b0;
         r_card_ready <= 1'b0;
      end else begin
         r_state    <= w_next_state;
         r_init_en  <= (w_next_state == GRANT_I);
         r_write_en <= (w_next_state == GRANT_W);
         r_read_en  <= (w_next_state == GRANT_R);
         if ((r_state == GRANT_I) && init_done) r_card_ready <= 1'b1;
         if (w_grant_entry && (w_next_state == GRANT_W)) r_last <= WRITE;
         if (w_grant_entry && (w_next_state == GRANT_R)) r_last <= READ;
      end
   end

`ifdef SD_ARB_TIMEOUT_EN
   localparam logic [c_cnt_w-1:0] c_timeout_val = c_cnt_w'(TIMEOUT_EDGES);

   logic               w_in_grant;
   logic               w_wd_rollover;
   logic [c_cnt_w-1:0] w_unused_wd_count;
   logic               r_timeout_err;

   assign w_in_grant = (r_state == GRANT_I) || (r_state == GRANT_W) ||
                       (r_state == GRANT_R);

   // Cleared on grant entry, so the count is zero in the first grant cycle.
   flex_counter #(
      .NUM_CNT_BITS (c_cnt_w)
   ) u_watchdog (
      .clk           (clk),
      .n_rst         (n_rst),
      .clear         (w_grant_entry),
      .count_enable  (w_in_grant && rising_edge_sclk),
      .rollover_val  (c_timeout_val),
      .count_out     (w_unused_wd_count),
      .rollover_flag (w_wd_rollover)
   );

   assign w_timeout = w_in_grant && w_wd_rollover;

   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         r_timeout_err <= 1'b0;
      end else if (w_grant_entry) begin
         r_timeout_err <= 1'b0;
      end else if (w_timeout) begin
         r_timeout_err <= 1'b1;
      end
   end

   assign timeout_err = r_timeout_err;
`else
   logic [c_cnt_w-1:0] w_unused_cfg;

   assign w_unused_cfg = {c_cnt_w{rising_edge_sclk}};
   assign w_timeout    = 1'b0;
   assign timeout_err  = 1'b0;
`endif

   // ------------------------------------------------------------------------
   // Shifter mux, driven from the registered grant. Idle bus keeps CS high.
   // ------------------------------------------------------------------------
   always_comb begin
      sd_command    = '0;
      sd_CS         = 1'b1;
      load_command  = 1'b0;
      shift_command = 1'b0;
      shift_read    = 1'b0;
      load_data     = 1'b0;
      shift_data    = 1'b0;
      if (r_init_en) begin
         sd_command    = init_command;
         sd_CS         = init_CS;
         load_command  = init_load_command;
         shift_command = init_shift_command;
         shift_read    = init_shift_read;
         load_data     = init_load_data;
         shift_data    = init_shift_data;
      end else if (r_write_en) begin
         sd_command    = write_command;
         sd_CS         = write_CS;
         load_command  = write_load_command;
         shift_command = write_shift_command;
         shift_read    = write_shift_read;
         load_data     = write_load_data;
         shift_data    = write_shift_data;
      end else if (r_read_en) begin
         sd_command    = read_command;
         sd_CS         = read_CS;
         load_command  = read_load_command;
         shift_command = read_shift_command;
         shift_read    = read_shift_read;
         load_data     = read_load_data;
         shift_data    = read_shift_data;
      end
   end

   assign init_enable  = r_init_en;
   assign write_enable = r_write_en;
   assign read_enable  = r_read_en;
   assign card_ready   = r_card_ready;
   assign busy         = (r_state != IDLE);

endmodule
`default_nettype wire

// File: tb/tb_sd_bus_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_sd_bus_arbiter
//  Description : Self-checking bench for sd_bus_arbiter. Expected grant
//                order is queued when requests are driven and popped when a
//                grant appears. Define SD_ARB_TIMEOUT_EN to exercise the
//                watchdog with TIMEOUT_EDGES = 16.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_sd_bus_arbiter;

`ifdef SD_ARB_TIMEOUT_EN
   localparam int TB_TIMEOUT = 16;
`else
   localparam int TB_TIMEOUT = 4096;
`endif

   logic        clk, n_rst, rising_edge_sclk;
   logic        init_req, write_req, read_req;
   logic        init_done, write_done, read_done;
   logic [47:0] init_command, write_command, read_command;
   logic        init_CS, init_load_command, init_shift_command, init_shift_read;
   logic        init_load_data, init_shift_data;
   logic        write_CS, write_load_command, write_shift_command, write_shift_read;
   logic        write_load_data, write_shift_data;
   logic        read_CS, read_load_command, read_shift_command, read_shift_read;
   logic        read_load_data, read_shift_data;
   logic        init_enable, write_enable, read_enable;
   logic [47:0] sd_command;
   logic        sd_CS, load_command, shift_command, shift_read, load_data, shift_data;
   logic        card_ready, busy, timeout_err;

   int n_run  = 0;
   int n_fail = 0;
   int exp_q[$];

   sd_bus_arbiter #(.TIMEOUT_EDGES(TB_TIMEOUT)) dut (
      .clk(clk), .n_rst(n_rst), .rising_edge_sclk(rising_edge_sclk),
      .init_req(init_req), .write_req(write_req), .read_req(read_req),
      .init_done(init_done), .write_done(write_done), .read_done(read_done),
      .init_command(init_command), .write_command(write_command),
      .read_command(read_command),
      .init_CS(init_CS), .init_load_command(init_load_command),
      .init_shift_command(init_shift_command), .init_shift_read(init_shift_read),
      .init_load_data(init_load_data), .init_shift_data(init_shift_data),
      .write_CS(write_CS), .write_load_command(write_load_command),
      .write_shift_command(write_shift_command), .write_shift_read(write_shift_read),
      .write_load_data(write_load_data), .write_shift_data(write_shift_data),
      .read_CS(read_CS), .read_load_command(read_load_command),
      .read_shift_command(read_shift_command), .read_shift_read(read_shift_read),
      .read_load_data(read_load_data), .read_shift_data(read_shift_data),
      .init_enable(init_enable), .write_enable(write_enable),
      .read_enable(read_enable), .sd_command(sd_command), .sd_CS(sd_CS),
      .load_command(load_command), .shift_command(shift_command),
      .shift_read(shift_read), .load_data(load_data), .shift_data(shift_data),
      .card_ready(card_ready), .busy(busy), .timeout_err(timeout_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   // 0=init 1=write 2=read 3=none 4=not one-hot
   function automatic int grant_id();
      case ({init_enable, write_enable, read_enable})
         3'b100:  return 0;
         3'b010:  return 1;
         3'b001:  return 2;
         3'b000:  return 3;
         default: return 4;
      endcase
   endfunction

   task automatic wait_grant(input int max_cyc, output int cyc);
      cyc = 0;
      while (grant_id() == 3 && cyc < max_cyc) begin
         tick();
         cyc++;
      end
   endtask

   task automatic test_reset;
      #2;
      n_run++;
      if (grant_id() !== 3 || sd_CS !== 1'b1 || sd_command !== 48'h0 ||
          {load_command, shift_command, shift_read, load_data, shift_data} !== 5'b0 ||
          card_ready !== 1'b0 || timeout_err !== 1'b0 || busy !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_state: grant=%0d cs=%b cmd=%h ctl=%b%b%b%b%b rdy=%b to=%b busy=%b expected none,1,0,00000,0,0,0",
                  grant_id(), sd_CS, sd_command, load_command, shift_command,
                  shift_read, load_data, shift_data, card_ready, timeout_err, busy);
      end
      tick(); tick();
      n_rst = 1'b1;
      tick();
   endtask

   task automatic test_init_gating;
      int got, exp;
      write_req = 1'b1;
      repeat (3) tick();
      n_run++;
      if (write_enable !== 1'b0 || busy !== 1'b0) begin
         n_fail++;
         $display("FAIL write_gated: write_enable=%b busy=%b expected 0 0", write_enable, busy);
      end
      init_req     = 1'b1;
      init_command = 48'h400000000095;
      init_CS      = 1'b0;
      exp_q.push_back(0);
      tick();
      got = grant_id();
      exp = exp_q.pop_front();
      n_run++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL init_latency: grant=%0d expected %0d", got, exp);
      end
      n_run++;
      if (sd_command !== 48'h400000000095 || sd_CS !== 1'b0 || card_ready !== 1'b0) begin
         n_fail++;
         $display("FAIL init_mux: cmd=%h cs=%b rdy=%b expected 400000000095 0 0",
                  sd_command, sd_CS, card_ready);
      end
      init_done = 1'b1; init_req = 1'b0; write_req = 1'b0;
      tick();
      init_done = 1'b0;
      n_run++;
      if (init_enable !== 1'b0 || busy !== 1'b1 || sd_CS !== 1'b1 || card_ready !== 1'b1) begin
         n_fail++;
         $display("FAIL init_release: en=%b busy=%b cs=%b rdy=%b expected 0 1 1 1",
                  init_enable, busy, sd_CS, card_ready);
      end
      tick();
      n_run++;
      if (busy !== 1'b0 || grant_id() !== 3 || card_ready !== 1'b1) begin
         n_fail++;
         $display("FAIL init_idle: busy=%b grant=%0d rdy=%b expected 0 none 1",
                  busy, grant_id(), card_ready);
      end
   endtask

   task automatic test_round_robin;
      int got, exp, cyc;
      write_req = 1'b1; read_req = 1'b1;
      exp_q.push_back(1); exp_q.push_back(2); exp_q.push_back(1); exp_q.push_back(2);
      for (int g = 0; g < 4; g++) begin
         wait_grant(8, cyc);
         got = grant_id();
         exp = exp_q.pop_front();
         n_run++;
         if (got !== exp) begin
            n_fail++;
            $display("FAIL rr_order%0d: grant=%0d expected %0d", g, got, exp);
         end
         n_run++;
         if (cyc !== ((g == 0) ? 1 : 2)) begin
            n_fail++;
            $display("FAIL rr_gap%0d: cycles=%0d expected %0d", g, cyc, (g == 0) ? 1 : 2);
         end
         tick();
         if (g == 3) begin write_req = 1'b0; read_req = 1'b0; end
         if (exp == 1) write_done = 1'b1; else read_done = 1'b1;
         tick();
         write_done = 1'b0; read_done = 1'b0;
         n_run++;
         if (grant_id() !== 3 || sd_CS !== 1'b1) begin
            n_fail++;
            $display("FAIL rr_release%0d: grant=%0d cs=%b expected none 1", g, grant_id(), sd_CS);
         end
      end
      tick(); tick();
      n_run++;
      if (grant_id() !== 3 || busy !== 1'b0) begin
         n_fail++;
         $display("FAIL rr_quiet: grant=%0d busy=%b expected none 0", grant_id(), busy);
      end
   endtask

   task automatic test_mux;
      int got, exp, cyc;
      write_req = 1'b1;
      exp_q.push_back(1);
      wait_grant(4, cyc);
      got = grant_id();
      exp = exp_q.pop_front();
      n_run++;
      if (got !== exp || cyc !== 1) begin
         n_fail++;
         $display("FAIL mux_grant: grant=%0d cycles=%0d expected %0d 1", got, cyc, exp);
      end
      write_req = 1'b0;
      write_command = 48'h580000000095; read_command = 48'h510000000000;
      init_command  = 48'hFFFFFFFFFFFF;
      write_CS = 1'b0; read_CS = 1'b1; write_shift_data = 1'b1;
      read_load_data = 1'b1; init_load_command = 1'b1;
      #1;
      n_run++;
      if (sd_command !== 48'h580000000095 || sd_CS !== 1'b0 || shift_data !== 1'b1 ||
          load_data !== 1'b0 || load_command !== 1'b0) begin
         n_fail++;
         $display("FAIL mux_write: cmd=%h cs=%b sd=%b ld=%b lc=%b expected 580000000095 0 1 0 0",
                  sd_command, sd_CS, shift_data, load_data, load_command);
      end
      write_CS = 1'b1;
      #1;
      n_run++;
      if (sd_CS !== 1'b1) begin
         n_fail++;
         $display("FAIL mux_cs_follow: cs=%b expected 1", sd_CS);
      end
      write_CS = 1'b0;
      read_done = 1'b1; init_done = 1'b1;
      tick();
      read_done = 1'b0; init_done = 1'b0;
      tick();
      n_run++;
      if (write_enable !== 1'b1) begin
         n_fail++;
         $display("FAIL foreign_done: write_enable=%b expected 1", write_enable);
      end
      write_done = 1'b1;
      tick();
      write_done = 1'b0;
      tick();
      n_run++;
      if (grant_id() !== 3 || busy !== 1'b0 || sd_command !== 48'h0 || sd_CS !== 1'b1 ||
          shift_data !== 1'b0) begin
         n_fail++;
         $display("FAIL mux_idle: grant=%0d busy=%b cmd=%h cs=%b sd=%b expected none 0 0 1 0",
                  grant_id(), busy, sd_command, sd_CS, shift_data);
      end
   endtask

   task automatic test_timeout;
      int got, exp, cyc;
      read_req = 1'b1;
      exp_q.push_back(2);
      wait_grant(4, cyc);
      got = grant_id();
      exp = exp_q.pop_front();
      n_run++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL to_grant: grant=%0d expected %0d", got, exp);
      end
      read_req = 1'b0;
`ifdef SD_ARB_TIMEOUT_EN
      for (int k = 0; k < 16; k++) begin
         if (k == 15) begin
            n_run++;
            if (read_enable !== 1'b1 || timeout_err !== 1'b0) begin
               n_fail++;
               $display("FAIL to_early: read_enable=%b timeout_err=%b expected 1 0",
                        read_enable, timeout_err);
            end
         end
         rising_edge_sclk = 1'b1;
         tick();
         rising_edge_sclk = 1'b0;
         tick();
      end
      n_run++;
      if (read_enable !== 1'b0 || timeout_err !== 1'b1 || card_ready !== 1'b1 || busy !== 1'b1) begin
         n_fail++;
         $display("FAIL to_abort: en=%b err=%b rdy=%b busy=%b expected 0 1 1 1",
                  read_enable, timeout_err, card_ready, busy);
      end
      write_req = 1'b1;
      exp_q.push_back(1);
      wait_grant(6, cyc);
      got = grant_id();
      exp = exp_q.pop_front();
      n_run++;
      if (got !== exp || timeout_err !== 1'b0) begin
         n_fail++;
         $display("FAIL to_clear: grant=%0d err=%b expected %0d 0", got, timeout_err, exp);
      end
      write_req = 1'b0;
      write_done = 1'b1;
      tick();
      write_done = 1'b0;
      tick();
`else
      for (int k = 0; k < 40; k++) begin
         rising_edge_sclk = 1'b1;
         tick();
         rising_edge_sclk = 1'b0;
         tick();
      end
      n_run++;
      if (read_enable !== 1'b1 || timeout_err !== 1'b0) begin
         n_fail++;
         $display("FAIL no_watchdog: read_enable=%b timeout_err=%b expected 1 0",
                  read_enable, timeout_err);
      end
      read_done = 1'b1;
      tick();
      read_done = 1'b0;
      tick();
`endif
   endtask

   task automatic test_reset_mid_grant;
      int got, exp, cyc;
      write_req = 1'b1;
      write_CS  = 1'b0;
      exp_q.push_back(1);
      wait_grant(6, cyc);
      got = grant_id();
      exp = exp_q.pop_front();
      n_run++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL rst_grant: grant=%0d expected %0d", got, exp);
      end
      #2;
      n_rst = 1'b0;
      #1;
      n_run++;
      if (write_enable !== 1'b0 || sd_CS !== 1'b1 || card_ready !== 1'b0 || busy !== 1'b0) begin
         n_fail++;
         $display("FAIL rst_async: en=%b cs=%b rdy=%b busy=%b expected 0 1 0 0",
                  write_enable, sd_CS, card_ready, busy);
      end
      write_req = 1'b0;
      tick();
      n_rst = 1'b1;
      tick();
      n_run++;
      if (grant_id() !== 3 || card_ready !== 1'b0) begin
         n_fail++;
         $display("FAIL rst_after: grant=%0d rdy=%b expected none 0", grant_id(), card_ready);
      end
   endtask

   initial begin
      n_rst = 1'b0; rising_edge_sclk = 1'b0;
      init_req = 1'b0; write_req = 1'b0; read_req = 1'b0;
      init_done = 1'b0; write_done = 1'b0; read_done = 1'b0;
      init_command = '0; write_command = '0; read_command = '0;
      init_CS = 1'b1; init_load_command = 1'b0; init_shift_command = 1'b0;
      init_shift_read = 1'b0; init_load_data = 1'b0; init_shift_data = 1'b0;
      write_CS = 1'b1; write_load_command = 1'b0; write_shift_command = 1'b0;
      write_shift_read = 1'b0; write_load_data = 1'b0; write_shift_data = 1'b0;
      read_CS = 1'b1; read_load_command = 1'b0; read_shift_command = 1'b0;
      read_shift_read = 1'b0; read_load_data = 1'b0; read_shift_data = 1'b0;

      test_reset();
      test_init_gating();
      test_round_robin();
      test_mux();
      test_timeout();
      test_reset_mid_grant();

      $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL global_timeout: simulation exceeded time limit");
      $fatal(1, "time limit");
   end

endmodule
`default_nettype wire
